// File: rtl/swv_waveform_sequencer_if.sv
// DAC code handshake between the waveform sequencer and the serial DAC controller.
interface swv_waveform_sequencer_if #(
  parameter int DAC_WIDTH = 8
);
  logic [DAC_WIDTH-1:0] dac_data;
  logic                 dac_valid;
  logic                 dac_ready;

  modport master (output dac_data, output dac_valid, input dac_ready);
  modport slave  (input dac_data, input dac_valid, output dac_ready);
endinterface

// File: rtl/swv_waveform_sequencer.sv
// Square-wave voltammetry waveform sequencer: staircase, SWV and cyclic SWV
// DAC code generation with valid/ready output and ADC sample strobes.
module swv_waveform_sequencer #(
  parameter int DAC_WIDTH      = 8,
  parameter int PERIOD_WIDTH   = 24,
  parameter int STEP_CNT_WIDTH = 16
) (
  input  logic                      ti_clk,
  input  logic                      rst,
  input  logic [DAC_WIDTH-1:0]      cfg_start,
  input  logic [DAC_WIDTH-1:0]      cfg_stop,
  input  logic [DAC_WIDTH-1:0]      cfg_step,
  input  logic [DAC_WIDTH-1:0]      cfg_amp,
  input  logic [PERIOD_WIDTH-1:0]   cfg_half_period,
  input  logic [1:0]                cfg_mode,
  input  logic                      start_trig,
  input  logic                      abort_trig,
  swv_waveform_sequencer_if.master  dacBus,
  output logic                      sample_fwd,
  output logic                      sample_rev,
  output logic [STEP_CNT_WIDTH-1:0] step_index,
  output logic                      busy,
  output logic                      shield,
  output logic                      done
);

  // Two extra bits give a sign bit and one overflow bit for base +/- amp/step.
  localparam int AW = DAC_WIDTH + 2;
  localparam logic [PERIOD_WIDTH-1:0]   P_ZERO = {PERIOD_WIDTH{1'b0}};
  localparam logic [PERIOD_WIDTH-1:0]   P_ONE  = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [STEP_CNT_WIDTH-1:0] S_ZERO = {STEP_CNT_WIDTH{1'b0}};
  localparam logic [STEP_CNT_WIDTH-1:0] S_ONE  = {{(STEP_CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DAC_WIDTH-1:0]      D_ZERO = {DAC_WIDTH{1'b0}};
  localparam logic [DAC_WIDTH-1:0]      D_MAX  = {DAC_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    FWD_OUT  = 3'd2,
    FWD_WAIT = 3'd3,
    REV_OUT  = 3'd4,
    REV_WAIT = 3'd5,
    ADVANCE  = 3'd6,
    DONE     = 3'd7
  } state_t;

  state_t                    state_r;
  logic [DAC_WIDTH-1:0]      start_r, stop_r, step_r, amp_r, base_r;
  logic [PERIOD_WIDTH-1:0]   halfPeriod_r, cnt_r;
  logic [1:0]                mode_r;
  logic                      up_r, returned_r;
  logic [STEP_CNT_WIDTH-1:0] stepIdx_r;
  logic [DAC_WIDTH-1:0]      dacData_r;
  logic                      dacValid_r, sampleFwd_r, sampleRev_r;
  logic                      busy_r, shield_r, done_r;

  logic [PERIOD_WIDTH-1:0]   halfEff_s;
  logic signed [AW-1:0]      nextBase_s, target_s, returnBase_s;
  logic                      ended_s;

  function automatic logic signed [AW-1:0] ext(input logic [DAC_WIDTH-1:0] v);
    return $signed({2'b00, v});
  endfunction

  // Clamp a signed intermediate into the unsigned DAC code range.
  function automatic logic [DAC_WIDTH-1:0] sat(input logic signed [AW-1:0] v);
    logic [DAC_WIDTH-1:0] r;
    if (v[AW-1]) begin
      r = D_ZERO;
    end else if (v[AW-2]) begin
      r = D_MAX;
    end else begin
      r = v[DAC_WIDTH-1:0];
    end
    return r;
  endfunction

  // Forward phase code: plain base on a staircase, otherwise offset in sweep direction.
  function automatic logic [DAC_WIDTH-1:0] fwdCode(input logic [DAC_WIDTH-1:0] b,
                                                   input logic [DAC_WIDTH-1:0] a,
                                                   input logic up,
                                                   input logic [1:0] m);
    logic [DAC_WIDTH-1:0] r;
    if (m == 2'd0) begin
      r = b;
    end else if (up) begin
      r = sat(ext(b) + ext(a));
    end else begin
      r = sat(ext(b) - ext(a));
    end
    return r;
  endfunction

  // Reverse phase code: offset against the sweep direction.
  function automatic logic [DAC_WIDTH-1:0] revCode(input logic [DAC_WIDTH-1:0] b,
                                                   input logic [DAC_WIDTH-1:0] a,
                                                   input logic up);
    logic [DAC_WIDTH-1:0] r;
    if (up) begin
      r = sat(ext(b) - ext(a));
    end else begin
      r = sat(ext(b) + ext(a));
    end
    return r;
  endfunction

  // Step arithmetic and end-of-sweep detection from the latched configuration.
  always_comb begin
    halfEff_s    = halfPeriod_r;
    nextBase_s   = ext(base_r);
    target_s     = ext(stop_r);
    returnBase_s = ext(stop_r);
    ended_s      = 1'b0;
    if (halfPeriod_r == P_ZERO) begin
      halfEff_s = P_ONE;
    end else begin
      halfEff_s = halfPeriod_r;
    end
    if (returned_r) begin
      target_s = ext(start_r);
    end else begin
      target_s = ext(stop_r);
    end
    if (up_r) begin
      nextBase_s   = ext(base_r) + ext(step_r);
      returnBase_s = ext(stop_r) - ext(step_r);
      if (returnBase_s < ext(start_r)) begin
        returnBase_s = ext(start_r);
      end else begin
        returnBase_s = returnBase_s;
      end
      ended_s = (nextBase_s > target_s);
    end else begin
      nextBase_s   = ext(base_r) - ext(step_r);
      returnBase_s = ext(stop_r) + ext(step_r);
      if (returnBase_s > ext(start_r)) begin
        returnBase_s = ext(start_r);
      end else begin
        returnBase_s = returnBase_s;
      end
      ended_s = (nextBase_s < target_s);
    end
    if ((step_r == D_ZERO) || (ext(base_r) == target_s)) begin
      ended_s = 1'b1;
    end else begin
      ended_s = ended_s;
    end
  end

  // Sequencer FSM with all outputs registered; abort overrides everything but reset.
  always_ff @(posedge ti_clk) begin
    if (rst) begin
      state_r      <= IDLE;
      start_r      <= D_ZERO;
      stop_r       <= D_ZERO;
      step_r       <= D_ZERO;
      amp_r        <= D_ZERO;
      base_r       <= D_ZERO;
      halfPeriod_r <= P_ZERO;
      cnt_r        <= P_ZERO;
      mode_r       <= 2'd0;
      up_r         <= 1'b0;
      returned_r   <= 1'b0;
      stepIdx_r    <= S_ZERO;
      dacData_r    <= D_ZERO;
      dacValid_r   <= 1'b0;
      sampleFwd_r  <= 1'b0;
      sampleRev_r  <= 1'b0;
      busy_r       <= 1'b0;
      shield_r     <= 1'b0;
      done_r       <= 1'b0;
    end else if (abort_trig) begin
      state_r     <= IDLE;
      dacValid_r  <= 1'b0;
      sampleFwd_r <= 1'b0;
      sampleRev_r <= 1'b0;
      busy_r      <= 1'b0;
      shield_r    <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      sampleFwd_r <= 1'b0;
      sampleRev_r <= 1'b0;
      done_r      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_trig) begin
            state_r  <= LOAD;
            busy_r   <= 1'b1;
            shield_r <= 1'b1;
          end
        end
        LOAD: begin
          start_r      <= cfg_start;
          stop_r       <= cfg_stop;
          step_r       <= cfg_step;
          amp_r        <= cfg_amp;
          halfPeriod_r <= cfg_half_period;
          mode_r       <= cfg_mode;
          base_r       <= cfg_start;
          up_r         <= (cfg_stop >= cfg_start);
          returned_r   <= 1'b0;
          stepIdx_r    <= S_ZERO;
          dacData_r    <= fwdCode(cfg_start, cfg_amp, (cfg_stop >= cfg_start), cfg_mode);
          dacValid_r   <= 1'b1;
          state_r      <= FWD_OUT;
        end
        FWD_OUT: begin
          if (dacBus.dac_ready) begin
            dacValid_r  <= 1'b0;
            cnt_r       <= P_ONE;
            sampleFwd_r <= (halfEff_s == P_ONE);
            state_r     <= FWD_WAIT;
          end
        end
        FWD_WAIT: begin
          if (cnt_r == halfEff_s) begin
            if (mode_r == 2'd0) begin
              state_r <= ADVANCE;
            end else begin
              dacData_r  <= revCode(base_r, amp_r, up_r);
              dacValid_r <= 1'b1;
              state_r    <= REV_OUT;
            end
          end else begin
            cnt_r       <= cnt_r + P_ONE;
            sampleFwd_r <= ((cnt_r + P_ONE) == halfEff_s);
          end
        end
        REV_OUT: begin
          if (dacBus.dac_ready) begin
            dacValid_r  <= 1'b0;
            cnt_r       <= P_ONE;
            sampleRev_r <= (halfEff_s == P_ONE);
            state_r     <= REV_WAIT;
          end
        end
        REV_WAIT: begin
          if (cnt_r == halfEff_s) begin
            state_r <= ADVANCE;
          end else begin
            cnt_r       <= cnt_r + P_ONE;
            sampleRev_r <= ((cnt_r + P_ONE) == halfEff_s);
          end
        end
        ADVANCE: begin
          stepIdx_r <= stepIdx_r + S_ONE;
          if (!ended_s) begin
            base_r     <= nextBase_s[DAC_WIDTH-1:0];
            dacData_r  <= fwdCode(nextBase_s[DAC_WIDTH-1:0], amp_r, up_r, mode_r);
            dacValid_r <= 1'b1;
            state_r    <= FWD_OUT;
          end else if ((mode_r == 2'd2) && !returned_r && (start_r != stop_r)) begin
            // Turn around for the return sweep, one step back from the stop code.
            returned_r <= 1'b1;
            up_r       <= !up_r;
            base_r     <= returnBase_s[DAC_WIDTH-1:0];
            dacData_r  <= fwdCode(returnBase_s[DAC_WIDTH-1:0], amp_r, !up_r, mode_r);
            dacValid_r <= 1'b1;
            state_r    <= FWD_OUT;
          end else begin
            done_r  <= 1'b1;
            state_r <= DONE;
          end
        end
        DONE: begin
          busy_r   <= 1'b0;
          shield_r <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          dacValid_r <= 1'b0;
          busy_r     <= 1'b0;
          shield_r   <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign dacBus.dac_data  = dacData_r;
  assign dacBus.dac_valid = dacValid_r;
  assign sample_fwd       = sampleFwd_r;
  assign sample_rev       = sampleRev_r;
  assign step_index       = stepIdx_r;
  assign busy             = busy_r;
  assign shield           = shield_r;
  assign done             = done_r;

endmodule

// File: doc/swv_waveform_sequencer.md
Name: swv_waveform_sequencer

Overview:
Parametrised successor to the single-channel square-wave voltammetry (SWV) engine. Generates DAC codes for three modes: plain staircase, square-wave-on-staircase, and cyclic (forward then return sweep) SWV. Codes go to a serial DAC controller through a valid/ready handshake. ADC sample strobes are emitted at the end of each half-period. Sits between the host wire/trigger endpoints and the DAC controller; its shield output selects it over pipe-driven DAC data.

Parameters:
DAC_WIDTH, 8, width of every DAC code and configuration code
PERIOD_WIDTH, 24, width of the half-period counter in ti_clk cycles
STEP_CNT_WIDTH, 16, width of the completed-step counter

Ports:
ti_clk  in  1  sole clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
cfg_start  in  DAC_WIDTH  staircase start code
cfg_stop  in  DAC_WIDTH  staircase end code; sweep direction is up if cfg_stop >= cfg_start, otherwise down
cfg_step  in  DAC_WIDTH  staircase increment, unsigned
cfg_amp  in  DAC_WIDTH  square-wave amplitude, unsigned
cfg_half_period  in  PERIOD_WIDTH  ti_clk cycles per half-period; 0 is treated as 1
cfg_mode  in  2  0 = staircase, 1 = SWV, 2 = cyclic SWV, 3 = reserved (behaves as 1)
start_trig  in  1  one-cycle start pulse
abort_trig  in  1  one-cycle abort pulse
dac_data  out  DAC_WIDTH  code offered to the DAC controller
dac_valid  out  1  dac_data is valid
dac_ready  in  1  DAC controller accepts dac_data this cycle
sample_fwd  out  1  one-cycle pulse at the end of a forward (or staircase) half-period
sample_rev  out  1  one-cycle pulse at the end of a reverse half-period
step_index  out  STEP_CNT_WIDTH  number of completed staircase steps
busy  out  1  high from LOAD through DONE
shield  out  1  high while busy; the engine owns the DAC
done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset: synchronous, active-high. Every output is 0, the state is IDLE and all latched configuration is cleared.
- States: IDLE, LOAD, FWD_OUT, FWD_WAIT, REV_OUT, REV_WAIT, ADVANCE, DONE.
- IDLE:
  - start_trig moves to LOAD.
  - start_trig is ignored in every other state.
- LOAD (1 cycle):
  - Latches all cfg_* inputs; later changes to cfg_* have no effect until the next start.
  - Sets base = cfg_start and the direction flag; clears step_index and the cyclic "returned" flag.
  - Sets busy = shield = 1.
- FWD_OUT:
  - dac_valid = 1 and dac_data = fwd code.
  - fwd code = base in mode 0; sat(base + amp) for an up sweep; sat(base - amp) for a down sweep.
  - A transfer occurs in the cycle where dac_valid and dac_ready are both high (call it cycle T). The state then moves to FWD_WAIT and dac_valid drops at T+1.
  - dac_data is held stable while dac_valid is high and dac_ready is low.
- FWD_WAIT:
  - The counter runs for H = max(cfg_half_period, 1) cycles. sample_fwd pulses at cycle T+H.
  - In mode 0 the next state is ADVANCE; in other modes it is REV_OUT.
- REV_OUT / REV_WAIT:
  - Same as the forward phase, with rev code = sat(base - amp) for an up sweep or sat(base + amp) for a down sweep.
  - sample_rev pulses at the end of the half-period; the next state is ADVANCE.
- Arithmetic: performed at DAC_WIDTH+2 bits signed. sat() clamps to the range 0 .. 2^DAC_WIDTH - 1.
- ADVANCE (1 cycle):
  - step_index increments, wrapping modulo 2^STEP_CNT_WIDTH.
  - next = base ± step. The sweep has ended if next passes the target: target is stop (forward) or start (return), step == 0, or base == target.
  - Not ended: base = next, go to FWD_OUT.
  - Ended, in mode 2 with the returned flag clear: set the returned flag, invert the direction, set base = stop - step (up) or stop + step (down) clamped toward start, and go to FWD_OUT. If start == stop, go straight to DONE.
  - Ended, otherwise: go to DONE.
- DONE (1 cycle): done = 1; busy and shield drop the next cycle; return to IDLE.
- Handshake timing: the next phase's dac_valid rises in the cycle after its sample pulse.
- abort_trig, in any state:
  - Next cycle: IDLE, dac_valid = busy = shield = 0.
  - No done and no sample pulse that cycle.
  - step_index keeps its value.
- start_trig and abort_trig in the same cycle while in IDLE: abort wins and the engine stays IDLE.
- rst has priority over everything, mid-operation included.

Test Plan:
- Mode 0, start = 10, stop = 14, step = 2, half = 4, dac_ready tied high -> dac_data 10, 12, 14. Three sample_fwd pulses spaced 6 cycles apart. No sample_rev. done one cycle after the third ADVANCE; step_index = 3.
- Mode 1, start = 100, stop = 96, step = 2, amp = 5, half = 3 -> codes 95, 105, 93, 103, 91, 101. Alternating fwd/rev strobes; done asserted; step_index = 3.
- Saturation: mode 1, start = 2, stop = 253, step = 251, amp = 10, DAC_WIDTH = 8 -> codes 12, 0, 255, 243; then done.
- Mode 2, start = 0, stop = 4, step = 2, amp = 1, half = 1 -> bases 0, 2, 4, 2, 0 with codes (1, 0), (3, 1), (5, 3), (1, 3), (0, 1) (fwd, rev); step_index = 5.
- Backpressure: dac_ready low for 7 cycles while FWD_OUT -> dac_valid held, dac_data stable. Counter does not run until the transfer; sample_fwd occurs exactly H cycles after the accepting cycle.
- Abort during REV_WAIT, then a new start_trig -> IDLE next cycle, with shield = dac_valid = 0 and no done pulse. The restart reloads the new cfg values and clears step_index to 0.
